prio_encoder_q: RTL
===================

# prio_encoder_q

Parametrised, registered priority encoder for N request lines, generalising our fixed 8-to-3 encoder.
- Captures requests into a pending register, either on level or on rising edge.
- Applies a per-line enable mask.
- Presents the winning index on a valid/ready handshake, with fixed or round-robin priority.
- Sits between raw event/interrupt lines and a consumer FSM that services one index at a time.

## Interface
Parameters:
- N, 8, number of request lines (2..32)
- IDXW, 3, code width; must equal ceil(log2(N))
- EDGE, 1, 1 = pending set on rising edge of req_in; 0 = pending set while req_in high
- RR, 0, 0 = fixed priority, highest index wins; 1 = round-robin

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_in  input  N  request lines, synchronous to clk
- mask  input  N  1 = line eligible for grant; pending bits still accumulate when masked
- code_out  output  IDXW  granted index
- code_valid  output  1  code_out valid
- code_ready  input  1  consumer accepts code_out
- pending_out  output  N  current pending register
- none_out  output  1  registered: no eligible pending bit (pending & mask == 0) and code_valid == 0

One clock; reset is asynchronous and active-low.

## Operation
- Reset (rst_n low, asynchronous):
  - pending, req_d, code_out, code_valid and last_grant go to 0; none_out goes to 1; FSM goes to IDLE.
- Capture:
  - set = req_in & ~req_d when EDGE=1; set = req_in when EDGE=0. req_d is req_in registered.
  - pending_next = (pending & ~clr) | set, so set wins over clear.
  - clr is a one-hot at code_out on handshake (code_valid & code_ready), zero otherwise.
  - Repeated edges on an already-pending line merge into one pending bit; no count is kept.
  - In EDGE=1, a line already high at reset release produces an edge on the first cycle.
- Eligibility: elig = pending & mask, using current register values, not pending_next.
- Fixed priority (RR=0): winner is the highest set index of elig.
- Round-robin (RR=1):
  - Search order is last_grant-1, last_grant-2, …, 0, N-1, …, last_grant. The index granted last is lowest priority.
  - last_grant updates to code_out on each handshake.
  - With last_grant=0 after reset, the order equals fixed priority.
- FSM:
  - IDLE: if elig != 0, load code_out = winner, set code_valid = 1, go to PRESENT. Otherwise stay.
  - PRESENT: hold code_out and code_valid stable regardless of mask, req_in or higher-priority arrivals; no retraction.
  - PRESENT: on code_ready = 1, clear that pending bit, set code_valid = 0, return to IDLE.
- Ready: code_ready while code_valid = 0 is ignored.
- Arithmetic: code_out is the binary index, zero-extended to IDXW. Indices ≥ N are never produced.

## Timing
- Request-to-valid latency, with an idle FSM and mask bit 1:
  - req_in high at edge k sets pending after edge k.
  - code_valid rises after edge k+1, i.e. 2 cycles.
- Throughput: at most one grant per 2 cycles; the IDLE cycle after each handshake is mandatory.
- Same-line re-request:
  - In EDGE=1, a new rising edge of the granted line in the handshake cycle re-sets its pending bit.
  - That line is then eligible in the next IDLE cycle.
- Level mode: a line held high is re-granted every 2 cycles while it remains the winner.
- Mask changes take effect in the next IDLE evaluation.
- Mid-operation reset: code_valid drops immediately and asynchronously, and all pending bits are lost.
- none_out is registered from the same-cycle state and is valid after each edge.

## Test plan
- Reset/priority, N=8, RR=0, mask=FF: reset, pulse req_in=8'b0010_0100 for 1 cycle.
  - Required: code_out=5 then code_out=2, each valid 2 cycles after its eligibility.
  - Required: none_out=1 at the end; pending_out=00.
- Hold: with code_valid high on index 5 and code_ready=0 for 10 cycles, raise req_in[7].
  - Required: code_out stays 5.
  - Required: after ready, 7 is granted, then 2.
- Mask: mask=8'h7F, pulse req_in[7] and req_in[1].
  - Required: grant 1 only; pending_out[7] stays 1.
  - Then set mask=FF. Required: 7 is granted 2 cycles later.
- Round-robin, RR=1, EDGE=0: hold req_in=8'b1000_0001 and code_ready=1.
  - Required: grants alternate 7, 0, 7, 0, one per 2 cycles.
- Edge merge and set-beats-clear, EDGE=1: pulse req_in[3] three times while masked.
  - Required: a single grant after unmask.
  - Then pulse req_in[3] in its handshake cycle. Required: a second grant of 3.
- Async reset while code_valid=1: assert rst_n low mid-cycle.
  - Required: code_valid=0 and pending_out=0 before the next edge.
  - Required: after release with req_in[4] held high, EDGE=1, code_out=4 valid 2 cycles later.

Source files
------------

// File: rtl/prio_encoder_q.sv
// prio_encoder_q: registered N-line priority encoder with a pending register,
// a per-line eligibility mask, fixed or round-robin arbitration, and a
// valid/ready output stage that presents one granted index at a time.
//
// Handshake: code_out is transferred on a rising clk edge where
// code_valid && code_ready. Once code_valid rises, code_out and code_valid
// stay stable until that transfer; code_ready is ignored while code_valid
// is low.
module prio_encoder_q #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int EDGE = 1,
  parameter int RR   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  input  logic [N-1:0]    mask,
  output logic [IDXW-1:0] code_out,
  output logic            code_valid,
  input  logic            code_ready,
  output logic [N-1:0]    pending_out,
  output logic            none_out
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    req_prev_q, req_prev_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [IDXW-1:0] code_q, code_d;
  logic [IDXW-1:0] last_q, last_d;
  logic            valid_q, valid_d;
  logic            none_q, none_d;

  logic [N-1:0]    set_v;
  logic [N-1:0]    clr_v;
  logic [N-1:0]    elig;
  logic [IDXW-1:0] winner;
  logic            hs;

  assign hs   = valid_q & code_ready;
  assign elig = pending_q & mask;

  // Capture: new requests (level or rising edge) merge into pending; a set
  // arriving in the handshake cycle wins over the clear of the granted line.
  always_comb begin
    req_prev_d = req_in;
    set_v      = (EDGE != 0) ? (req_in & ~req_prev_q) : req_in;
    clr_v      = '0;
    if (hs) clr_v[code_q] = 1'b1;
    pending_d  = (pending_q & ~clr_v) | set_v;
  end

  // Winner search: walk indices base-1, base-2, ... wrapping, ending at base.
  // Base is last_grant in round-robin mode and 0 in fixed mode, which makes
  // the fixed order N-1 down to 0. Later loop iterations have higher
  // priority, so the loop runs from the lowest-priority offset upward.
  always_comb begin
    int base;
    int idx;
    winner = '0;
    base   = (RR != 0) ? int'(last_q) : 0;
    idx    = 0;
    for (int off = N; off >= 1; off--) begin
      idx = base + N - off;
      if (idx >= N) idx = idx - N;
      if (elig[idx[IDXW-1:0]]) winner = idx[IDXW-1:0];
    end
  end

  // Output FSM: load the winner in IDLE, hold it in PRESENT until accepted.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    last_d  = last_q;
    none_d  = ~(|elig) & ~valid_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          code_d  = winner;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = code_q;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_prev_q <= '0;
      pending_q  <= '0;
      code_q     <= '0;
      last_q     <= '0;
      valid_q    <= 1'b0;
      none_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      none_q     <= none_d;
    end
  end

  assign code_out    = code_q;
  assign code_valid  = valid_q;
  assign pending_out = pending_q;
  assign none_out    = none_q;

endmodule
